muldiv_seq: RTL and testbench

Parametrised sequential multiply/divide unit that generalises the current multiplier into one block serving MULT, MULTU, DIV and DIVU. It sits beside the register bank, takes operands from the A and B registers, and drives the HI and LO registers through the existing HI/LO source muxes. A start/busy/done handshake lets the control unit hold in a wait state until the result is ready.

---
 rtl/muldiv_if.sv | 18 +
 rtl/muldiv_seq.sv | 117 +++++++++++
 tb/tb_muldiv_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Handshake and operand/result bundle between the control unit and the
// sequential multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b,
                  input  busy, done, div_zero, hi, lo);
  modport slave  (input  start, op, a, b,
                  output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/muldiv_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit: magnitude shift-add multiply or
// restoring divide over WIDTH steps, then a single sign-fix cycle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic   clk,
  input  logic   reset,
  muldiv_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]         state;
  logic [WIDTH-1:0]   cnt;
  logic [1:0]         op_q;
  logic               sa, sb;
  logic [WIDTH-1:0]   m;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dz_q;

  // Operand magnitudes; op[0]=0 selects the signed variants.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign a_neg = ~bus.op[0] & bus.a[WIDTH-1];
  assign b_neg = ~bus.op[0] & bus.b[WIDTH-1];
  assign mag_a = a_neg ? -bus.a : bus.a;
  assign mag_b = b_neg ? -bus.b : bus.b;

  // Multiply step: conditionally add multiplicand to upper half, shift right.
  logic [WIDTH:0] msum;
  assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                {1'b0, (acc[0] ? m : {WIDTH{1'b0}})};

  // Divide step: remainder in upper half, dividend shifting out / quotient in.
  logic [WIDTH:0]   shl;
  logic [WIDTH+1:0] diff;
  logic             dneg;
  assign shl  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff = {1'b0, shl} - {2'b0, m};
  assign dneg = diff[WIDTH+1];

  logic [2*WIDTH-1:0] step_nxt;
  always_comb begin
    step_nxt = {msum, acc[WIDTH-1:1]};
    if (op_q[1])
      step_nxt = {(dneg ? shl[WIDTH-1:0] : diff[WIDTH-1:0]), acc[WIDTH-2:0], ~dneg};
  end

  // Sign correction applied in FIX.
  logic               sgn;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;
  assign sgn      = ~op_q[0];
  assign prod_fix = (sgn & (sa ^ sb)) ? -acc : acc;
  assign q_fix    = (sgn & (sa ^ sb)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix    = (sgn & sa) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      m      <= '0;
      acc    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          if (bus.op[1] && bus.b == '0) begin
            done_q <= 1'b1;
            dz_q   <= 1'b1;
          end else begin
            op_q  <= bus.op;
            sa    <= a_neg;
            sb    <= b_neg;
            m     <= bus.op[1] ? mag_b : mag_a;
            acc   <= {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= step_nxt;
          cnt <= cnt + WIDTH'(1);
          if (cnt == WIDTH'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          if (op_q[1]) begin
            hi_q <= r_fix;
            lo_q <= q_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq against a 64-bit arithmetic
// reference model.
module tb_muldiv_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;
  logic [W-1:0] last_hi = '0, last_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero
  // and % takes the dividend's sign, matching the required semantics.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l);
    longint x, y;
    logic [63:0] p;
    x = op[0] ? longint'({32'b0, a}) : longint'($signed(a));
    y = op[0] ? longint'({32'b0, b}) : longint'($signed(b));
    if (!op[1]) begin
      p = x * y;
      h = p[63:32];
      l = p[31:0];
    end else begin
      p = x / y;
      l = p[31:0];
      p = x % y;
      h = p[31:0];
    end
  endfunction

  // Called just after a clock edge; issues one operation and checks it.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eh, el;
    int n, busy_cnt;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
    if (op[1] && b == '0) begin
      chk("dz_done", bus.done, 1);
      chk("dz_flag", bus.div_zero, 1);
      chk("dz_busy", bus.busy, 0);
      chk("dz_hi", bus.hi, last_hi);
      chk("dz_lo", bus.lo, last_lo);
      @(posedge clk); #1;
      chk("dz_done_drop", bus.done, 0);
      return;
    end
    busy_cnt = 0;
    n = 0;
    while (!bus.done && n < W + 10) begin
      if (bus.busy) busy_cnt++;
      chk("no_dz", bus.div_zero, 0);
      @(posedge clk); #1;
      n++;
    end
    model(op, a, b, eh, el);
    chk("latency", n, W + 1);
    chk("busy_cycles", busy_cnt, W + 1);
    chk("busy_low_at_done", bus.busy, 0);
    chk("dz_low", bus.div_zero, 0);
    chk($sformatf("hi op%0d %h %h", op, a, b), bus.hi, eh);
    chk($sformatf("lo op%0d %h %h", op, a, b), bus.lo, el);
    last_hi = eh;
    last_lo = el;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'(unsigned'($urandom_range(0, 9)));
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int guard;
    logic seen_done;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dz", bus.div_zero, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5);
    chk("plan_mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("plan_mult_lo", bus.lo, 32'hFFFF_FFF1);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("plan_multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("plan_multu_lo", bus.lo, 32'h0000_0001);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("plan_mult_m1_hi", bus.hi, 0);
    chk("plan_mult_m1_lo", bus.lo, 1);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    chk("plan_div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("plan_div_hi", bus.hi, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("plan_wrap_lo", bus.lo, 32'h8000_0000);
    chk("plan_wrap_hi", bus.hi, 0);
    run_op(2'b11, 32'd7, 32'd2);
    chk("plan_divu_lo", bus.lo, 3);
    chk("plan_divu_hi", bus.hi, 1);
    run_op(2'b11, 32'd9, 32'd0);
    chk("plan_dz_hi", bus.hi, 1);
    chk("plan_dz_lo", bus.lo, 3);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [W-1:0] a, b;
      op = 2'($urandom);
      a = pick();
      b = pick();
      run_op(op, a, b);
    end

    // Abort a multiply with reset; an ignored second start lands at cycle 5.
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd6; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      bus.start = (c == 5); bus.a = 32'd100; bus.b = 32'd3;
      @(posedge clk); #1;
      chk("abort_busy", bus.busy, 1);
    end
    bus.start = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("abort_busy0", bus.busy, 0);
    chk("abort_done0", bus.done, 0);
    chk("abort_hi0", bus.hi, 0);
    chk("abort_lo0", bus.lo, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < W + 8; c++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    chk("abort_no_done", seen_done, 0);
    last_hi = '0;
    last_lo = '0;
    run_op(2'b00, 32'd6, 32'd7);
    chk("post_rst_lo", bus.lo, 42);
    chk("post_rst_hi", bus.hi, 0);

    guard = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
